shift_seq_unit: RTL and testbench

- Sequential barrel-less shifter that consumes the 32-bit operand selected by the shift-source mux and the shift amount, then shifts one bit position per clock.
- Sits directly downstream of the shift-source mux in the multicycle datapath.
- Handshakes with the control FSM via start/busy/done.
- Its result feeds the register-file write-data mux.

---
 rtl/shift_seq_unit.sv | 114 +++++++++++
 tb/tb_shift_seq_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_unit.sv
// rtl/shift_seq_unit.sv - sequential one-bit-per-clock shifter with start/busy/done handshake
module shift_seq_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         op_r;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   step_val;
    logic               start_pass;

    // Opcodes 101..111 need no shifting at all, so they finish like a zero shift.
    assign start_pass = op[2] & (op[1] | op[0]);

    // Handshake outputs decode the state register only; no input reaches them combinationally.
    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);

    // One-bit step of the working register for the latched operation.
    always_comb begin
        step_val = data_out;
        case (op_r)
            OP_SLL:  step_val = {data_out[WIDTH-2:0], 1'b0};
            OP_SRL:  step_val = {1'b0, data_out[WIDTH-1:1]};
            OP_SRA:  step_val = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            OP_ROR:  step_val = {data_out[0], data_out[WIDTH-1:1]};
            OP_ROL:  step_val = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            default: step_val = data_out;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start is only honoured from IDLE and is never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((shamt == '0) || start_pass) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture operands on an accepted start, then step once per SHIFT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            op_r     <= '0;
            count    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        data_out <= data_in;
                        op_r     <= op;
                        count    <= shamt;
                    end
                end
                S_SHIFT: begin
                    data_out <= step_val;
                    count    <= count - 1'b1;
                end
                default: begin
                    data_out <= data_out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_unit.sv
// tb/tb_shift_seq_unit.sv - self-checking bench for shift_seq_unit
module tb_shift_seq_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    shift_seq_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .data_in  (data_in),
        .shamt    (shamt),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed directly from the operation definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] d, input int s);
        logic signed [31:0] sd;
        sd = d;
        case (o)
            3'd0:    return d << s;
            3'd1:    return d >> s;
            3'd2:    return sd >>> s;
            3'd3:    return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
            3'd4:    return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
            default: return d;
        endcase
    endfunction

    function automatic int ref_busy(input logic [2:0] o, input int s);
        if (o >= 3'd5) return 0;
        return s;
    endfunction

    // Issue one operation and check busy length, done pulse, result and hold.
    // disturb: pulse start with different operands mid-operation (and during DONE).
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input int s,
                          input string name, input bit disturb);
        logic [31:0] exp_val;
        int          exp_busy;
        int          busy_cnt;
        bit          got_done;
        exp_val  = ref_result(o, d, s);
        exp_busy = ref_busy(o, s);
        start    = 1'b1;
        op       = o;
        data_in  = d;
        shamt    = 5'(s);
        @(negedge clk);
        start    = 1'b0;
        op       = 3'($urandom);
        data_in  = $urandom;
        shamt    = 5'($urandom);
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (disturb && busy_cnt == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        vectors++;
        if (!got_done) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done within 40 cycles (busy count %0d)", name, busy_cnt);
        end
        vectors++;
        if (busy_cnt !== exp_busy) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        vectors++;
        if (data_out !== exp_val) begin
            miscompares++;
            $display("FAIL %s data_out: got %08h expected %08h", name, data_out, exp_val);
        end
        if (disturb) begin
            start   = 1'b1;
            data_in = ~exp_val;
            op      = 3'd7;
            shamt   = 5'd0;
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || data_out !== exp_val) begin
            miscompares++;
            $display("FAIL %s after_done: done=%b busy=%b data_out=%08h expected 0 0 %08h",
                     name, done, busy, data_out, exp_val);
        end
        if (disturb) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0 || data_out !== exp_val) begin
                miscompares++;
                $display("FAIL %s start_in_done_ignored: done=%b busy=%b data_out=%08h expected 0 0 %08h",
                         name, done, busy, data_out, exp_val);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: data_out=%08h busy=%b done=%b expected 00000000 0 0", data_out, busy, done);
        end
        reset = 1'b0;
        @(negedge clk);
        // Mid-operation reset: SLL 0xFF by 20, abandoned after 5 steps.
        start   = 1'b1;
        op      = 3'd0;
        data_in = 32'h0000_00FF;
        shamt   = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (data_out !== 32'h0000_1FE0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_check: data_out=%08h busy=%b expected 00001fe0 1", data_out, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_shift: data_out=%08h busy=%b done=%b expected 00000000 0 0", data_out, busy, done);
        end
        reset = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (done || busy) stray++;
            end
            vectors++;
            if (stray != 0) begin
                miscompares++;
                $display("FAIL reset_no_done: %0d cycles with busy/done after reset, expected 0", stray);
            end
        end
    endtask

    task automatic test_shifts;
        run_op(3'd0, 32'h0000_00F1, 4,  "sll_4",   1'b0);
        run_op(3'd1, 32'h8000_0000, 31, "srl_31",  1'b0);
        run_op(3'd2, 32'h8000_0010, 4,  "sra_neg", 1'b0);
        run_op(3'd2, 32'h7000_0000, 4,  "sra_pos", 1'b0);
        run_op(3'd3, 32'h0000_0001, 1,  "ror_1",   1'b0);
        run_op(3'd4, 32'h8000_0001, 4,  "rol_4",   1'b0);
    endtask

    task automatic test_zero_pass;
        run_op(3'd0, 32'hDEAD_BEEF, 0, "zero_shamt", 1'b0);
        run_op(3'd7, 32'hDEAD_BEEF, 7, "pass_111",   1'b0);
        run_op(3'd5, 32'h1234_5678, 31, "pass_101",  1'b0);
    endtask

    task automatic test_ignore_start;
        run_op(3'd0, 32'h0000_00F1, 4,  "ignore_sll", 1'b1);
        run_op(3'd2, 32'h8000_0010, 9,  "ignore_sra", 1'b1);
    endtask

    task automatic test_back_to_back;
        run_op(3'd1, 32'hF000_000F, 3, "b2b_a", 1'b0);
        run_op(3'd4, 32'h0F00_00F0, 8, "b2b_b", 1'b0);
        run_op(3'd0, 32'hCAFE_F00D, 0, "b2b_c", 1'b0);
        run_op(3'd3, 32'h0000_0003, 31, "b2b_d", 1'b0);
    endtask

    task automatic test_random;
        for (int n = 0; n < 150; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 31), "random", n[0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        op          = 3'd0;
        data_in     = 32'h0;
        shamt       = 5'd0;
        @(negedge clk);
        test_reset;
        test_shifts;
        test_zero_pass;
        test_ignore_start;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
